// File: rtl/instr_encoder.sv
// Sequential instruction encoder/loader: turns class+field requests into 32-bit
// words written to IMEM. Optional XOR checksum output under INSTR_ENC_CHECKSUM_EN.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cls,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [6:0]        count,
  output logic              busy,
  output logic              full,
  output logic              err
`ifdef INSTR_ENC_CHECKSUM_EN
  , output logic [31:0]     checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t      state, nxt;
  logic        acc, legal, wr;
  logic [31:0] enc;

  assign acc = in_valid && in_ready;
  assign wr  = acc && legal;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (in_cls)
      3'd0: enc = {6'd54, in_rs, in_rt, in_rd, 5'd0, in_funct};
      3'd1: enc = {6'd40, in_rs, in_rt, in_imm};
      3'd2: enc = {6'd39, in_rs, in_rt, in_imm};
      3'd3: enc = {6'd41, in_rs, in_rt, in_imm};
      3'd4: enc = {6'd42, in_rs, in_rt, in_imm};
      3'd5: enc = {6'd31, in_rs, in_rt, in_imm};
      3'd6: enc = {6'd32, in_target};
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: begin
        if (start)       nxt = LOAD;
        else if (finish) nxt = IDLE;
        else if (wr && count == 7'(DEPTH - 1)) nxt = FULL;
      end
      FULL: begin
        if (start)       nxt = LOAD;
        else if (finish) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // mem_addr doubles as the write pointer: it shows the address of the word being
  // written while mem_we is high and advances after that cycle, so a restart
  // landing on an in-flight write lets it complete at its old address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      full      <= 1'b0;
      mem_we    <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_wdata <= '0;
      count     <= '0;
`ifdef INSTR_ENC_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      state    <= nxt;
      in_ready <= (nxt == LOAD);
      busy     <= (nxt != IDLE);
      full     <= (nxt == FULL);
      mem_we   <= wr;
      err      <= acc && !legal;
      if (wr) mem_wdata <= enc;
      if (start)       mem_addr <= ADDR_W'(BASE_ADDR);
      else if (mem_we) mem_addr <= mem_addr + ADDR_W'(4);
      if (start)   count <= wr ? 7'd1 : 7'd0;
      else if (wr) count <= count + 7'd1;
`ifdef INSTR_ENC_CHECKSUM_EN
      if (start)   checksum <= wr ? enc : '0;
      else if (wr) checksum <= checksum ^ enc;
`endif
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic against a session-level reference model.
module tb_instr_encoder;

  localparam int AW = 5;
  localparam int DP = 6;
  localparam int BA = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_cls = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]    in_funct = '0;
  logic [15:0]   in_imm = '0;
  logic [25:0]   in_target = '0;
  logic          mem_we, busy, full, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [6:0]    count;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int checks = 0;
  int failures = 0;

  instr_encoder #(.ADDR_W(AW), .DEPTH(DP), .BASE_ADDR(BA)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_cls(in_cls),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .busy(busy), .full(full), .err(err)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state (session view, not the RTL's registers)
  bit          m_open, m_full, e_we, e_err;
  int          m_cnt, m_ptr, e_addr;
  logic [31:0] e_data, e_ck;

  function automatic logic [31:0] ref_enc(int cls, int rs, int rt, int rd, int fn, int imm, int tgt);
    longint op, w;
    case (cls)
      1: op = 40; 2: op = 39; 3: op = 41; 4: op = 42; 5: op = 31;
      default: op = 0;
    endcase
    if (cls == 0)      w = 54 * 2**26 + rs * 2**21 + rt * 2**16 + rd * 2**11 + fn;
    else if (cls == 6) w = 32 * 2**26 + tgt;
    else               w = op * 2**26 + rs * 2**21 + rt * 2**16 + imm;
    return w[31:0];
  endfunction

  task automatic model_reset();
    m_open = 0; m_full = 0; m_cnt = 0; m_ptr = BA;
    e_we = 0; e_err = 0; e_addr = BA; e_data = '0; e_ck = '0;
  endtask

  // Called at a negedge: applies inputs, predicts the post-edge outputs, waits one cycle.
  task automatic drive(input bit s, input bit f, input bit v, input int cls,
                       input int rs, input int rt, input int rd, input int fn,
                       input int imm, input int tgt);
    bit acc;
    int waddr;
    start = s; finish = f; in_valid = v; in_cls = 3'(cls);
    in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_funct = 6'(fn);
    in_imm = 16'(imm); in_target = 26'(tgt);
    acc = v && m_open && !m_full;
    e_we = 0; e_err = 0; waddr = 0;
    if (s) begin m_ptr = BA; m_cnt = 0; e_ck = '0; end
    if (acc && cls == 7) e_err = 1;
    else if (acc) begin
      e_data = ref_enc(cls, rs, rt, rd, fn, imm, tgt);
      waddr  = m_ptr;
      m_ptr  = (m_ptr + 4) % (1 << AW);
      m_cnt++;
      e_ck   = e_ck ^ e_data;
      e_we   = 1;
    end
    if (s)                         begin m_open = 1; m_full = 0; end
    else if (f)                    begin m_open = 0; m_full = 0; end
    else if (m_open && m_cnt == DP) m_full = 1;
    e_addr = e_we ? waddr : m_ptr;
    @(negedge clk);
    start = 0; finish = 0; in_valid = 0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({mem_we, err, in_ready, busy, full} !== 5'b0 || count !== 7'd0 ||
        mem_addr !== AW'(BA) || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset we=%b err=%b rdy=%b busy=%b full=%b cnt=%0d addr=%0d data=%h (want zeros, addr=%0d)",
               mem_we, err, in_ready, busy, full, count, mem_addr, mem_wdata, BA);
    end
    rst = 0;
    model_reset();
    idle();
  endtask

  task automatic test_rtype();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || count !== 7'd0 || mem_addr !== AW'(BA)) begin
      failures++;
      $display("FAIL start rdy=%b busy=%b cnt=%0d addr=%0d want 1 1 0 %0d", in_ready, busy, count, mem_addr, BA);
    end
    drive(0, 0, 1, 0, 1, 2, 3, 'h20, 0, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== AW'(BA) || mem_wdata !== 32'hD8221820 || count !== 7'd1) begin
      failures++;
      $display("FAIL rtype we=%b addr=%0d data=%h cnt=%0d want 1 %0d d8221820 1", mem_we, mem_addr, mem_wdata, count, BA);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 1, 1, 0, 4, 0, 0, 8, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== AW'(BA + 4) || mem_wdata !== 32'hA0040008) begin
      failures++;
      $display("FAIL b2b_lw we=%b addr=%0d data=%h want 1 %0d a0040008", mem_we, mem_addr, mem_wdata, BA + 4);
    end
    drive(0, 0, 1, 6, 0, 0, 0, 0, 0, 'h10);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== AW'((BA + 8) % 32) || mem_wdata !== 32'h80000010 || count !== 7'd3) begin
      failures++;
      $display("FAIL b2b_j we=%b addr=%0d data=%h cnt=%0d want 1 %0d 80000010 3", mem_we, mem_addr, mem_wdata, count, (BA + 8) % 32);
    end
  endtask

  task automatic test_illegal();
    drive(0, 0, 1, 7, 5, 5, 5, 5, 5, 5);
    checks++;
    if (err !== 1'b1 || mem_we !== 1'b0 || count !== 7'd3) begin
      failures++;
      $display("FAIL illegal err=%b we=%b cnt=%0d want 1 0 3", err, mem_we, count);
    end
    drive(0, 0, 1, 3, 1, 1, 0, 0, 'hFFFF, 0);
    checks++;
    if (err !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'hA421FFFF || mem_addr !== AW'(4) || count !== 7'd4) begin
      failures++;
      $display("FAIL addi err=%b we=%b data=%h addr=%0d cnt=%0d want 0 1 a421ffff 4 4", err, mem_we, mem_wdata, mem_addr, count);
    end
  endtask

  task automatic test_full();
    drive(0, 0, 1, 2, 3, 4, 0, 0, 'h1234, 0);
    drive(0, 0, 1, 5, 1, 2, 0, 0, 'hFFFE, 0);
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 7'(DP) || mem_addr !== AW'(12)) begin
      failures++;
      $display("FAIL full full=%b rdy=%b cnt=%0d addr=%0d want 1 0 %0d 12", full, in_ready, count, mem_addr, DP);
    end
    drive(0, 0, 1, 0, 9, 9, 9, 9, 0, 0);
    checks++;
    if (mem_we !== 1'b0 || count !== 7'(DP) || full !== 1'b1) begin
      failures++;
      $display("FAIL full_ignore we=%b cnt=%0d full=%b want 0 %0d 1", mem_we, count, full, DP);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (busy !== 1'b0 || full !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL finish busy=%b full=%b rdy=%b want 0 0 0", busy, full, in_ready);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (busy !== 1'b1 || count !== 7'd0 || mem_addr !== AW'(BA) || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL restart busy=%b cnt=%0d addr=%0d rdy=%b want 1 0 %0d 1", busy, count, mem_addr, in_ready, BA);
    end
  endtask

`ifdef INSTR_ENC_CHECKSUM_EN
  task automatic test_checksum();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 2, 3, 'h20, 0, 0);
    drive(0, 0, 1, 1, 0, 4, 0, 0, 8, 0);
    checks++;
    if (checksum !== 32'h78261828) begin
      failures++;
      $display("FAIL checksum got=%h want 78261828", checksum);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (checksum !== 32'd0) begin
      failures++;
      $display("FAIL checksum_clear got=%h want 0", checksum);
    end
  endtask
`endif

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 3, 2, 2, 0, 0, 7, 0);
    in_valid = 1; in_cls = 3'd1;
    @(posedge clk); #2;
    rst = 1; #1;
    checks++;
    if ({mem_we, err, in_ready, busy, full} !== 5'b0 || count !== 7'd0 ||
        mem_addr !== AW'(BA) || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL async_rst we=%b rdy=%b busy=%b full=%b cnt=%0d addr=%0d data=%h want reset values",
               mem_we, in_ready, busy, full, count, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_we cyc=%0d we=%b want 0", i, mem_we);
      end
    end
    in_valid = 0; rst = 0;
    model_reset();
    idle();
  endtask

  task automatic test_random();
    bit s, f, v;
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 99) < 4);
      f = ($urandom_range(0, 99) < 4);
      v = ($urandom_range(0, 99) < 80);
      drive(s, f, v, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
            $urandom_range(0, (1 << 26) - 1));
      checks++;
      if ({mem_we, err, in_ready, busy, full} !== {e_we, e_err, m_open && !m_full, m_open, m_full}) begin
        failures++;
        $display("FAIL rand_ctl cyc=%0d we,err,rdy,busy,full got=%b want=%b", i,
                 {mem_we, err, in_ready, busy, full}, {e_we, e_err, m_open && !m_full, m_open, m_full});
      end
      checks++;
      if (mem_addr !== AW'(e_addr) || count !== 7'(m_cnt)) begin
        failures++;
        $display("FAIL rand_ptr cyc=%0d addr=%0d cnt=%0d want %0d %0d", i, mem_addr, count, e_addr, m_cnt);
      end
      checks++;
      if (mem_wdata !== e_data) begin
        failures++;
        $display("FAIL rand_data cyc=%0d got=%h want=%h", i, mem_wdata, e_data);
      end
`ifdef INSTR_ENC_CHECKSUM_EN
      checks++;
      if (checksum !== e_ck) begin
        failures++;
        $display("FAIL rand_cksum cyc=%0d got=%h want=%h", i, checksum, e_ck);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_illegal();
    test_full();
`ifdef INSTR_ENC_CHECKSUM_EN
    test_checksum();
`endif
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
